// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MDU_LAT_DEF = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave the controller.
interface pipe_hazard_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_use_rt;
    logic        ID_jump;
    logic        EX_MemRead;
    logic [4:0]  EX_rt;
    logic        EX_branch_taken;
    logic        EX_mdu_start;
    logic        PC_Wr;
    logic        IFID_Wr;
    logic        IDEX_Wr;
    logic        IF_Flush;
    logic        IDEX_Bubble;
    logic        EXMEM_Bubble;
    logic        mdu_busy;
    logic [15:0] stall_cycles;

    modport master (
        output ID_rs, ID_rt, ID_use_rt, ID_jump, EX_MemRead, EX_rt,
               EX_branch_taken, EX_mdu_start,
        input  PC_Wr, IFID_Wr, IDEX_Wr, IF_Flush, IDEX_Bubble, EXMEM_Bubble,
               mdu_busy, stall_cycles
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rt, ID_jump, EX_MemRead, EX_rt,
               EX_branch_taken, EX_mdu_start,
        output PC_Wr, IFID_Wr, IDEX_Wr, IF_Flush, IDEX_Bubble, EXMEM_Bubble,
               mdu_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: a load in EX feeds a register read in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    output logic       load_use_o
);

    assign load_use_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                        ((ex_rt_i == id_rs_i) || (id_use_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use stall, branch/jump flush and multi-cycle MDU stall.
// The MDU stall is built only when PIPE_MDU_STALL_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  bus
);

    // The start cycle is one of the MDU_LAT EX cycles, leaving MDU_LAT-1 stall cycles.
    localparam logic [5:0] MDU_RELOAD = 6'(MDU_LAT - 2);

    pipe_state_e state_q;
    logic [5:0]  mdu_cnt_q;
    logic [15:0] stall_q;
    logic [15:0] stall_d;
    logic        lu_s;
    logic        start_s;
    logic        busy_s;
    logic        pc_wr_s;
    logic        ifid_wr_s;
    logic        idex_wr_s;
    logic        if_flush_s;
    logic        idex_bubble_s;
    logic        exmem_bubble_s;

    hazard_detect u_hazard_detect (
        .id_rs_i       (bus.ID_rs),
        .id_rt_i       (bus.ID_rt),
        .id_use_rt_i   (bus.ID_use_rt),
        .ex_mem_read_i (bus.EX_MemRead),
        .ex_rt_i       (bus.EX_rt),
        .load_use_o    (lu_s)
    );

`ifdef PIPE_MDU_STALL_EN
    assign start_s = bus.EX_mdu_start;
    assign busy_s  = (state_q == MDU_BUSY);
`else
    assign start_s = 1'b0;
    assign busy_s  = 1'b0;
`endif

    // Controller state: RUN / MDU_BUSY with the remaining-stall down-counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            mdu_cnt_q <= 6'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (start_s) begin
                        state_q   <= MDU_BUSY;
                        mdu_cnt_q <= MDU_RELOAD;
                    end else begin
                        state_q   <= RUN;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt_q == 6'd0) begin
                        state_q   <= RUN;
                    end else begin
                        mdu_cnt_q <= mdu_cnt_q - 6'd1;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    mdu_cnt_q <= 6'd0;
                end
            endcase
        end
    end

    // Pipeline control: reset forcing, MDU freeze, then branch > load-use > jump.
    always_comb begin
        pc_wr_s        = 1'b1;
        ifid_wr_s      = 1'b1;
        idex_wr_s      = 1'b1;
        if_flush_s     = 1'b0;
        idex_bubble_s  = 1'b0;
        exmem_bubble_s = 1'b0;
        if (!rst) begin
            pc_wr_s        = 1'b0;
            ifid_wr_s      = 1'b0;
            idex_wr_s      = 1'b0;
            if_flush_s     = 1'b1;
            idex_bubble_s  = 1'b1;
            exmem_bubble_s = 1'b1;
        end else if (busy_s) begin
            pc_wr_s        = 1'b0;
            ifid_wr_s      = 1'b0;
            idex_wr_s      = 1'b0;
            exmem_bubble_s = 1'b1;
        end else if (bus.EX_branch_taken) begin
            if_flush_s     = 1'b1;
            idex_bubble_s  = 1'b1;
        end else if (lu_s) begin
            pc_wr_s        = 1'b0;
            ifid_wr_s      = 1'b0;
            idex_bubble_s  = 1'b1;
        end else if (bus.ID_jump) begin
            if_flush_s     = 1'b1;
        end else begin
            pc_wr_s        = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_d = stall_q;
        if (!pc_wr_s) begin
            stall_d = sat_inc16(stall_q);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.PC_Wr        = pc_wr_s;
    assign bus.IFID_Wr      = ifid_wr_s;
    assign bus.IDEX_Wr      = idex_wr_s;
    assign bus.IF_Flush     = if_flush_s;
    assign bus.IDEX_Bubble  = idex_bubble_s;
    assign bus.EXMEM_Bubble = exmem_bubble_s;
    assign bus.mdu_busy     = busy_s;
    assign bus.stall_cycles = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 8, range 2..63: total EX occupancy of a multi-cycle mul/div op, in cycles.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_use_rt  in  1  ID instruction reads rt.
REQ-006 ID_jump  in  1  ID holds an unconditional jump.
REQ-007 EX_MemRead, EX_rt  in  1, 5  EX holds a load, and its destination register.
REQ-008 EX_branch_taken  in  1  branch resolved taken in EX.
REQ-009 EX_mdu_start  in  1  one-cycle pulse: mul/div op entered EX.
REQ-010 PC_Wr, IFID_Wr, IDEX_Wr  out  1 each  pipeline register write enables.
REQ-011 IF_Flush  out  1  drives IF/ID Flush.
REQ-012 IDEX_Bubble, EXMEM_Bubble  out  1 each  insert NOP into ID/EX or EX/MEM.
REQ-013 mdu_busy  out  1  high while state is MDU_BUSY.
REQ-014 stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-015 States: RUN, MDU_BUSY; 6-bit down-counter mdu_cnt.
REQ-016 Outputs combinational from state and inputs; defaults PC_Wr=IFID_Wr=IDEX_Wr=1, all others 0.
REQ-017 Load-use hazard (LU): EX_MemRead && EX_rt!=0 && (EX_rt==ID_rs || (ID_use_rt && EX_rt==ID_rt)).
REQ-018 RUN, LU: PC_Wr=0, IFID_Wr=0, IDEX_Bubble=1 for exactly that cycle; no registered state change.
REQ-019 RUN, EX_branch_taken: IF_Flush=1, IDEX_Bubble=1, PC_Wr=1; overrides LU and ID_jump in the same cycle.
REQ-020 RUN, ID_jump without LU or branch: IF_Flush=1 for one cycle; PC_Wr=1.
REQ-021 ID_jump with LU in the same cycle: stall wins, jump is processed in the next cycle.
REQ-022 RUN, EX_mdu_start: next state MDU_BUSY, mdu_cnt<=MDU_LAT-2; EX_mdu_start takes effect even if LU or ID_jump is also asserted.
REQ-023 MDU_BUSY: PC_Wr=IFID_Wr=IDEX_Wr=0, EXMEM_Bubble=1, IF_Flush=0; mdu_cnt decrements each cycle.
REQ-024 MDU_BUSY with mdu_cnt==0: last stall cycle; next state RUN.
REQ-025 EX_branch_taken, ID_jump and EX_mdu_start are ignored in MDU_BUSY.
REQ-026 stall_cycles increments on every cycle with PC_Wr==0 and rst high; holds at 16'hFFFF.

Reset
REQ-027 rst low at posedge: state RUN, mdu_cnt 0, stall_cycles 0.
REQ-028 While rst is low, outputs are forced: PC_Wr=IFID_Wr=IDEX_Wr=0, IF_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1.
REQ-029 rst low mid-MDU_BUSY aborts the op; the first cycle after release is in RUN.

Configuration
REQ-030 Macro PIPE_MDU_STALL_EN defined: MDU_BUSY, mdu_cnt and mdu_busy are implemented as above.
REQ-031 Macro not defined: state is fixed at RUN, EX_mdu_start is ignored, mdu_busy=0 and EXMEM_Bubble is driven only by reset.

Structure
REQ-032 Shared package pipe_pkg holds the state enum (RUN, MDU_BUSY), the REG_ZERO=5'd0 constant and the default MDU_LAT.
REQ-033 Sub-module hazard_detect is the purely combinational LU comparator (REQ-017); the FSM and counters stay in the top.

Verification
REQ-034 EX_MemRead=1, EX_rt=5, ID_rs=5 -> one cycle PC_Wr=0, IFID_Wr=0, IDEX_Bubble=1, stall_cycles=1.
REQ-035 EX_MemRead=1, EX_rt=0, ID_rs=0 -> no stall, all write enables 1.
REQ-036 EX_branch_taken=1 together with LU -> IF_Flush=1, IDEX_Bubble=1, PC_Wr=1.
REQ-037 MDU_LAT=8, EX_mdu_start pulse -> mdu_busy high for 7 cycles with EXMEM_Bubble=1, then RUN; stall_cycles=7.
REQ-038 rst low in the 3rd MDU_BUSY cycle -> forced reset outputs; after release state RUN, stall_cycles=0.
REQ-039 Hold LU for 70000 cycles -> stall_cycles saturates at 16'hFFFF.
